pixel_scan_ctrl: RTL and testbench
==================================

PIXEL_SCAN_CTRL -- requirements
Module: pixel_scan_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, is the pixel data width in bits.
REQ-002 Parameter IMG_W, default 256, is pixels per line (>=2).
REQ-003 Parameter IMG_H, default 256, is lines per frame (>=2).
REQ-004 Parameter COL_BIT, default 8, is the column coordinate width; 2^COL_BIT >= IMG_W.
REQ-005 Parameter ROW_BIT, default 8, is the row coordinate width; 2^ROW_BIT >= IMG_H.
REQ-006 Parameter KSIZE, default 3, is the odd filter window size (3..IMG_W).
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that arms a frame scan.
REQ-010 in_pixel  in  DATA_W  raster-order pixel data.
REQ-011 in_valid  in  1  in_pixel is valid.
REQ-012 in_ready  out  1  block accepts in_pixel this cycle.
REQ-013 out_pixel  out  DATA_W  registered pixel.
REQ-014 out_col  out  COL_BIT  column of out_pixel.
REQ-015 out_row  out  ROW_BIT  row of out_pixel.
REQ-016 out_valid  out  1  output beat valid.
REQ-017 out_ready  in  1  downstream accepts the output beat.
REQ-018 out_sof / out_eol / out_eof  out  1 each  beat is first pixel of frame / last of line / last of frame.
REQ-019 out_win_valid  out  1  beat completes a full KSIZE x KSIZE window: row >= KSIZE-1 and col >= KSIZE-1.
REQ-020 busy  out  1  high in ACTIVE or DRAIN.
REQ-021 frame_done  out  1  one-cycle pulse when the last beat of a frame leaves the block.

Function
REQ-022 FSM states IDLE, ACTIVE, DRAIN; reset state IDLE.
REQ-023 IDLE: in_ready=0; start=1 -> ACTIVE with col=0, row=0; other inputs ignored.
REQ-024 ACTIVE: in_ready = !out_valid || out_ready (one-deep output register, no bubble under continuous flow).
REQ-025 Accept: in_valid && in_ready; latches pixel, current col/row, and all flags into the output register, sets out_valid.
REQ-026 Column counter: modulo IMG_W, advances only on accept; wraps to 0 after IMG_W-1.
REQ-027 Row counter: advances only on accept with col=IMG_W-1; modulo IMG_H.
REQ-028 out_sof: col=0 && row=0; out_eol: col=IMG_W-1; out_eof: col=IMG_W-1 && row=IMG_H-1; all evaluated at accept time.
REQ-029 Accept of the eof pixel: counters return to 0, state -> DRAIN, in_ready falls the next cycle.
REQ-030 DRAIN: in_ready=0; when out_valid && out_ready with out_eof=1, frame_done=1 in that cycle, state -> IDLE.
REQ-031 out_valid clears on out_valid && out_ready with no simultaneous accept; held outputs stable while out_valid && !out_ready.
REQ-032 start during ACTIVE or DRAIN is ignored; a frame cannot restart mid-scan.
REQ-033 Simultaneous output consume and input accept in the same cycle: register reloads, out_valid stays 1.
REQ-034 Latency: accepted pixel appears on outputs the cycle after accept.

Reset
REQ-035 reset=1 in any state, including mid-frame: state IDLE, col=0, row=0, out_valid=0, in_ready=0, busy=0, frame_done=0, all flags 0, out_pixel=0, out_col=0, out_row=0 on the next edge.
REQ-036 reset dominates start in the same cycle; the partially scanned frame is discarded.

Verification (IMG_W=4, IMG_H=3, KSIZE=3, DATA_W=8)
REQ-037 start, then 12 pixels 0x00..0x0B with out_ready=1 -> 12 beats, col 0..3 repeating, row 0,0,0,0,1..2; sof on 0x00; eol on 0x03,0x07,0x0B; eof and frame_done on 0x0B.
REQ-038 Same frame -> out_win_valid=1 only on pixels 0x0A and 0x0B (row 2, col 2..3).
REQ-039 out_ready=0 after first beat for 5 cycles -> out_pixel=0x00 held, in_ready=0, no counter advance; resumes with 0x01 at col 1.
REQ-040 Reset after 6 accepted pixels, then start, then pixel 0xAA -> beat 0xAA with col=0, row=0, out_sof=1.
REQ-041 start pulse while busy=1 -> no effect; frame completes with exactly 12 beats and one frame_done.
REQ-042 in_valid=1 in IDLE without start -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/pixel_scan_if.sv
// Pixel stream bundle: input pixel handshake plus the registered output beat
// with its coordinates and frame/line markers.
interface pixel_scan_if #(
  parameter int DATA_W  = 8,
  parameter int COL_BIT = 8,
  parameter int ROW_BIT = 8
);
  logic [DATA_W-1:0]  in_pixel;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_pixel;
  logic [COL_BIT-1:0] out_col;
  logic [ROW_BIT-1:0] out_row;
  logic               out_valid;
  logic               out_ready;
  logic               out_sof;
  logic               out_eol;
  logic               out_eof;
  logic               out_win_valid;

  // Environment side: produces pixels, consumes beats.
  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_col, out_row, out_valid,
           out_sof, out_eol, out_eof, out_win_valid
  );

  // Scan controller side.
  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_col, out_row, out_valid,
           out_sof, out_eol, out_eof, out_win_valid
  );
endinterface

// File: rtl/pixel_scan_ctrl.sv
// Raster scan controller: tags each accepted pixel with its column/row and
// frame/line markers and presents it through a one-deep output register.
// A frame is armed by start, scanned in ACTIVE, and closed in DRAIN once the
// last beat has been taken downstream.
module pixel_scan_ctrl #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int COL_BIT = 8,
  parameter int ROW_BIT = 8,
  parameter int KSIZE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  pixel_scan_if.slave bus,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  localparam logic [COL_BIT-1:0] COL_LAST = COL_BIT'(IMG_W - 1);
  localparam logic [ROW_BIT-1:0] ROW_LAST = ROW_BIT'(IMG_H - 1);

  logic [1:0]         state_reg, state_next;
  logic [COL_BIT-1:0] col_reg, col_next;
  logic [ROW_BIT-1:0] row_reg, row_next;

  logic [DATA_W-1:0]  out_pixel_reg;
  logic [COL_BIT-1:0] out_col_reg;
  logic [ROW_BIT-1:0] out_row_reg;
  logic               out_valid_reg;
  logic               out_sof_reg;
  logic               out_eol_reg;
  logic               out_eof_reg;
  logic               out_win_reg;

  logic in_ready_int;
  logic accept;
  logic consume;
  logic at_col_last;
  logic at_row_last;
  logic sof_now;
  logic eol_now;
  logic eof_now;
  logic win_now;

  // Handshake decode: the output register frees up in the same cycle it is
  // consumed, so a continuous stream flows without bubbles.
  always_comb begin
    in_ready_int = (state_reg == ACTIVE) && (!out_valid_reg || bus.out_ready);
    accept       = bus.in_valid && in_ready_int;
    consume      = out_valid_reg && bus.out_ready;
  end

  // Position markers for the pixel currently being offered.  The window test
  // is done in int so a KSIZE wider than the row field can never alias.
  always_comb begin
    at_col_last = (col_reg == COL_LAST);
    at_row_last = (row_reg == ROW_LAST);
    sof_now     = (col_reg == '0) && (row_reg == '0);
    eol_now     = at_col_last;
    eof_now     = at_col_last && at_row_last;
    win_now     = (int'(col_reg) >= KSIZE - 1) && (int'(row_reg) >= KSIZE - 1);
  end

  // Frame completes when the end-of-frame beat leaves the block; that beat
  // can only be on the output while draining.
  always_comb begin
    frame_done = (state_reg == DRAIN) && consume && out_eof_reg;
    busy       = (state_reg != IDLE);
  end

  // Next-state and coordinate counter logic.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ACTIVE;
          col_next   = '0;
          row_next   = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (at_col_last) begin
            col_next = '0;
            if (at_row_last) begin
              row_next   = '0;
              state_next = DRAIN;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (frame_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        col_next   = '0;
        row_next   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  // One-deep output register: load on accept (even while the previous beat
  // is being consumed), clear valid on a consume with nothing new behind it,
  // hold everything while the downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_pixel_reg <= '0;
      out_col_reg   <= '0;
      out_row_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
      out_win_reg   <= 1'b0;
    end else if (accept) begin
      out_pixel_reg <= bus.in_pixel;
      out_col_reg   <= col_reg;
      out_row_reg   <= row_reg;
      out_valid_reg <= 1'b1;
      out_sof_reg   <= sof_now;
      out_eol_reg   <= eol_now;
      out_eof_reg   <= eof_now;
      out_win_reg   <= win_now;
    end else if (consume) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready_int;
  assign bus.out_pixel     = out_pixel_reg;
  assign bus.out_col       = out_col_reg;
  assign bus.out_row       = out_row_reg;
  assign bus.out_valid     = out_valid_reg;
  assign bus.out_sof       = out_sof_reg;
  assign bus.out_eol       = out_eol_reg;
  assign bus.out_eof       = out_eof_reg;
  assign bus.out_win_valid = out_win_reg;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Self-checking bench for pixel_scan_ctrl on a 4x3 image with a 3x3 window:
// a frame-level reference model is checked every cycle, plus directed
// scenarios with hand-written expectations.
module tb_pixel_scan_ctrl;
  localparam int DATA_W  = 8;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 3;
  localparam int COL_BIT = 2;
  localparam int ROW_BIT = 2;
  localparam int KSIZE   = 3;
  localparam int PIX     = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic frame_done;

  pixel_scan_if #(.DATA_W(DATA_W), .COL_BIT(COL_BIT), .ROW_BIT(ROW_BIT)) bus ();

  pixel_scan_ctrl #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .COL_BIT(COL_BIT), .ROW_BIT(ROW_BIT), .KSIZE(KSIZE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a sequence of PIX pixel indices; position and
  // markers follow from the index by plain arithmetic.
  bit              m_in_frame = 1'b0;   // between start and last beat taken
  int              m_acc      = 0;      // pixels accepted in this frame
  bit              m_v        = 1'b0;   // a beat is waiting downstream
  logic [7:0]      m_pix      = '0;
  int              m_idx      = 0;

  typedef struct {
    logic [7:0] pix;
    int         col;
    int         row;
    bit         sof, eol, eof, win;
  } beat_t;
  beat_t log_q[$];
  int    fd_count = 0;

  // Compare DUT against the model mid-cycle, then advance the model to what
  // the next rising edge must produce (inputs are stable from here to there).
  always @(negedge clk) begin
    bit exp_ready, exp_fd, acc, cons, was_idle;
    int ecol, erow;
    exp_ready = m_in_frame && (m_acc < PIX) && (!m_v || bus.out_ready);
    exp_fd    = m_v && bus.out_ready && (m_idx == PIX - 1);
    ecol      = m_idx % IMG_W;
    erow      = m_idx / IMG_W;
    if (cmp_en) begin
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        beat_t b;
        b.pix = bus.out_pixel; b.col = int'(bus.out_col); b.row = int'(bus.out_row);
        b.sof = bus.out_sof; b.eol = bus.out_eol; b.eof = bus.out_eof; b.win = bus.out_win_valid;
        log_q.push_back(b);
        $display("beat pix=%02h col=%0d row=%0d sof=%0b eol=%0b eof=%0b win=%0b",
                 b.pix, b.col, b.row, b.sof, b.eol, b.eof, b.win);
      end
      if (frame_done === 1'b1) fd_count++;
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_in_frame));
      check("out_valid", 32'(bus.out_valid), 32'(m_v));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      if (m_v) begin
        check("out_pixel", 32'(bus.out_pixel), 32'(m_pix));
        check("out_col", 32'(bus.out_col), 32'(ecol));
        check("out_row", 32'(bus.out_row), 32'(erow));
        check("out_sof", 32'(bus.out_sof), 32'(m_idx == 0));
        check("out_eol", 32'(bus.out_eol), 32'(ecol == IMG_W - 1));
        check("out_eof", 32'(bus.out_eof), 32'(m_idx == PIX - 1));
        check("out_win", 32'(bus.out_win_valid),
              32'((ecol >= KSIZE - 1) && (erow >= KSIZE - 1)));
      end
    end
    if (reset) begin
      m_in_frame = 1'b0; m_acc = 0; m_v = 1'b0; m_pix = '0; m_idx = 0;
    end else begin
      was_idle = !m_in_frame;
      acc  = bus.in_valid && exp_ready;
      cons = m_v && bus.out_ready;
      if (exp_fd) m_in_frame = 1'b0;
      if (acc) begin
        m_pix = bus.in_pixel; m_idx = m_acc; m_v = 1'b1; m_acc++;
      end else if (cons) begin
        m_v = 1'b0;
      end
      if (was_idle && start) begin
        m_in_frame = 1'b1; m_acc = 0;
      end
    end
  end

  // All driving tasks begin and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] p);
    bit ok = 1'b0;
    bus.in_pixel = p; bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    step();
    bus.in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    step();
    if (!ok) check("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [11:0] sof_mask, eol_mask, eof_mask, win_mask;
    int exp_row[12];
    sof_mask = 12'h001; eol_mask = 12'h888; eof_mask = 12'h800; win_mask = 12'hC00;
    exp_row  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    reset = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_pixel = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // Reset state and pixels offered while idle without start.
    bus.in_valid = 1'b1; bus.in_pixel = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;

    // Full frame with continuous downstream acceptance.
    log_q.delete(); fd_count = 0;
    pulse_start();
    for (int k = 0; k < PIX; k++) send_pixel(8'(k));
    wait_idle();
    check("f1_beats", 32'(log_q.size()), 32'd12);
    check("f1_frame_done", 32'(fd_count), 32'd1);
    for (int k = 0; k < log_q.size() && k < 12; k++) begin
      check("f1_pix", 32'(log_q[k].pix), 32'(k));
      check("f1_col", 32'(log_q[k].col), 32'(k % 4));
      check("f1_row", 32'(log_q[k].row), 32'(exp_row[k]));
      check("f1_sof", 32'(log_q[k].sof), 32'(sof_mask[k]));
      check("f1_eol", 32'(log_q[k].eol), 32'(eol_mask[k]));
      check("f1_eof", 32'(log_q[k].eof), 32'(eof_mask[k]));
      check("f1_win", 32'(log_q[k].win), 32'(win_mask[k]));
    end

    // Downstream stall after the first beat.
    log_q.delete(); fd_count = 0;
    pulse_start();
    send_pixel(8'h00);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_pixel = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pix", 32'(bus.out_pixel), 32'h00);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_col", 32'(bus.out_col), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    send_pixel(8'h01);
    @(negedge clk);
    check("resume_pix", 32'(bus.out_pixel), 32'h01);
    check("resume_col", 32'(bus.out_col), 32'd1);
    step();
    for (int k = 2; k < PIX; k++) send_pixel(8'(k));
    wait_idle();
    check("stall_beats", 32'(log_q.size()), 32'd12);
    check("stall_frame_done", 32'(fd_count), 32'd1);

    // Reset mid-frame (together with start), then a fresh frame.
    pulse_start();
    for (int k = 0; k < 6; k++) send_pixel(8'(k + 8'h40));
    reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_pix", 32'(bus.out_pixel), 32'd0);
    check("rst_col", 32'(bus.out_col), 32'd0);
    check("rst_row", 32'(bus.out_row), 32'd0);
    check("rst_flags", 32'({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_win_valid}), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    step();
    pulse_start();
    send_pixel(8'hAA);
    @(negedge clk);
    check("post_rst_pix", 32'(bus.out_pixel), 32'hAA);
    check("post_rst_col", 32'(bus.out_col), 32'd0);
    check("post_rst_row", 32'(bus.out_row), 32'd0);
    check("post_rst_sof", 32'(bus.out_sof), 32'd1);
    step();
    for (int k = 1; k < PIX; k++) send_pixel(8'(k));
    wait_idle();

    // start pulses while busy (mid-scan and during drain) are ignored.
    log_q.delete(); fd_count = 0;
    pulse_start();
    for (int k = 0; k < PIX; k++) begin
      send_pixel(8'(k + 8'h80));
      if (k == 4 || k == PIX - 1) pulse_start();
    end
    wait_idle();
    repeat (4) step();
    check("busy_start_beats", 32'(log_q.size()), 32'd12);
    check("busy_start_done", 32'(fd_count), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Random traffic against the model.
    fd_count = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_pixel  = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      start = (!busy && $urandom_range(0, 3) == 0) || ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    bus.in_valid = 1'b0; start = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("random_frames_done", 32'(fd_count >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
